// File: rtl/align_pp_accumulator_pkg.sv
// rtl/align_pp_accumulator_pkg.sv - shared MAC widths, FSM encoding and overflow helper
package align_pp_accumulator_pkg;

    localparam int MAC_PP_W  = 15;
    localparam int MAC_EXP_W = 6;
    localparam int NUM_W     = 51;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Two's-complement add overflowed: like-signed operands produced an unlike-signed result.
    function automatic logic signed_add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/align_pp_accumulator_pp_lane_adder.sv
// rtl/align_pp_accumulator_pp_lane_adder.sv - ADD/MX primitives and the masked lane-sum chain
module ADD #(
    parameter int W = 8
) (
    input  logic [W-1:0]  a_i,
    input  logic [W-1:0]  b_i,
    output logic [W-1:0]  s_o,
    output logic [50:0]   number
);
    assign s_o    = a_i + b_i;
    assign number = 51'(W);
endmodule

module MX #(
    parameter int W = 8
) (
    input  logic [W-1:0]  d0_i,
    input  logic [W-1:0]  d1_i,
    input  logic          sel_i,
    output logic [W-1:0]  y_o,
    output logic [50:0]   number
);
    assign y_o    = sel_i ? d1_i : d0_i;
    assign number = 51'(W);
endmodule

module pp_lane_adder
    import align_pp_accumulator_pkg::*;
#(
    parameter int LANES = 4,
    parameter int PP_W  = MAC_PP_W,
    parameter int ACC_W = 24
) (
    input  logic [LANES*PP_W-1:0] pp_i,
    input  logic [LANES-1:0]      lane_en_i,
    output logic [ACC_W-1:0]      sum_o,
    output logic [NUM_W-1:0]      number
);

    // Each lane owns its own running-sum signal so the chain has no self-referencing array.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [ACC_W-1:0] sext;
        logic [ACC_W-1:0] masked;
        logic [ACC_W-1:0] run;
        logic [NUM_W-1:0] mx_num;
        logic [NUM_W-1:0] cnt;

        assign sext = {{(ACC_W-PP_W){pp_i[k*PP_W+PP_W-1]}}, pp_i[k*PP_W +: PP_W]};

        MX #(.W(ACC_W)) u_mask (
            .d0_i   ('0),
            .d1_i   (sext),
            .sel_i  (lane_en_i[k]),
            .y_o    (masked),
            .number (mx_num)
        );

        if (k == 0) begin : g_first
            assign run = masked;
            assign cnt = mx_num;
        end else begin : g_next
            logic [NUM_W-1:0] add_num;
            ADD #(.W(ACC_W)) u_add (
                .a_i    (g_lane[k-1].run),
                .b_i    (masked),
                .s_o    (run),
                .number (add_num)
            );
            assign cnt = g_lane[k-1].cnt + mx_num + add_num;
        end
    end

    assign sum_o  = g_lane[LANES-1].run;
    assign number = g_lane[LANES-1].cnt;

endmodule

// File: rtl/align_pp_accumulator.sv
// rtl/align_pp_accumulator.sv - multi-beat aligned partial-product accumulator with result handshake
module align_pp_accumulator
    import align_pp_accumulator_pkg::*;
#(
    parameter int LANES = 4,
    parameter int PP_W  = MAC_PP_W,
    parameter int EXP_W = MAC_EXP_W,
    parameter int ACC_W = 24
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [LANES*PP_W-1:0] i_pp,
    input  logic [LANES-1:0]      i_lane_en,
    input  logic [EXP_W-1:0]      i_exp,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ACC_W-1:0]      o_sum,
    output logic [EXP_W-1:0]      o_exp,
    output logic                  o_ovf,
    output logic [50:0]           number
);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] lane_sum, acc_add, acc_sel;
    logic [NUM_W-1:0] lane_num, add_num, mx_num;
    logic             accept, ovf_now;

    pp_lane_adder #(.LANES(LANES), .PP_W(PP_W), .ACC_W(ACC_W)) u_lane_adder (
        .pp_i      (i_pp),
        .lane_en_i (i_lane_en),
        .sum_o     (lane_sum),
        .number    (lane_num)
    );

    ADD #(.W(ACC_W)) u_acc_add (
        .a_i    (acc_q),
        .b_i    (lane_sum),
        .s_o    (acc_add),
        .number (add_num)
    );

    // First beat of a group loads the lane sum; later beats take the accumulated value.
    MX #(.W(ACC_W)) u_acc_mx (
        .d0_i   (lane_sum),
        .d1_i   (acc_add),
        .sel_i  (state_q == ST_ACC),
        .y_o    (acc_sel),
        .number (mx_num)
    );

    assign o_ready = (state_q == ST_IDLE) || (state_q == ST_ACC);
    assign o_valid = (state_q == ST_HOLD);
    assign accept  = i_valid && o_ready;
    assign ovf_now = signed_add_ovf(acc_q[ACC_W-1], lane_sum[ACC_W-1], acc_add[ACC_W-1]);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        exp_d   = exp_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d   = acc_sel;
                    exp_d   = i_exp;
                    ovf_d   = 1'b0;
                    state_d = i_last ? ST_HOLD : ST_ACC;
                end
            end
            ST_ACC: begin
                if (accept) begin
                    acc_d   = acc_sel;
                    ovf_d   = ovf_q | ovf_now;
                    state_d = i_last ? ST_HOLD : ST_ACC;
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            exp_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            exp_q   <= exp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_sum  = acc_q;
    assign o_exp  = exp_q;
    assign o_ovf  = ovf_q;
    assign number = lane_num + add_num + mx_num;

endmodule

// File: tb/tb_align_pp_accumulator.sv
// tb/tb_align_pp_accumulator.sv - directed and randomized checks against an arithmetic reference model
module tb_align_pp_accumulator;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [59:0] i_pp;
    logic [3:0]  i_lane_en;
    logic [5:0]  i_exp;
    logic        i_last;
    logic        o_valid;
    logic        i_ready;
    logic [23:0] o_sum;
    logic [5:0]  o_exp;
    logic        o_ovf;
    logic [50:0] number_w;

    int n_checks = 0;
    int n_pass   = 0;

    longint m_acc;
    bit     m_ovf;
    bit     m_first;
    logic [5:0] m_exp;

    align_pp_accumulator dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_pp      (i_pp),
        .i_lane_en (i_lane_en),
        .i_exp     (i_exp),
        .i_last    (i_last),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_sum     (o_sum),
        .o_exp     (o_exp),
        .o_ovf     (o_ovf),
        .number    (number_w)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [59:0] pack4(input logic [14:0] l0, input logic [14:0] l1,
                                          input logic [14:0] l2, input logic [14:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic longint lane_sum_ref(input logic [59:0] pp, input logic [3:0] en);
        longint s = 0;
        longint v;
        for (int k = 0; k < 4; k++) begin
            v = longint'(pp[k*15 +: 15]);
            if (v >= 16384) v = v - 32768;
            if (en[k]) s = s + v;
        end
        return s;
    endfunction

    function automatic longint wrap24(input longint r);
        longint u = r & 64'hFFFFFF;
        return (u >= 64'h800000) ? u - 64'h1000000 : u;
    endfunction

    task automatic beat(input logic [59:0] pp, input logic [3:0] en, input logic [5:0] e, input bit last);
        longint ls, r;
        @(negedge i_clk);
        check("ready_before_beat", o_ready, 1);
        i_valid = 1'b1; i_pp = pp; i_lane_en = en; i_exp = e; i_last = last;
        @(posedge i_clk);
        #1 i_valid = 1'b0; i_last = 1'b0;
        ls = lane_sum_ref(pp, en);
        if (m_first) begin
            m_acc = ls; m_ovf = 1'b0; m_exp = e;
        end else begin
            r = m_acc + ls;
            if (r > 64'sd8388607 || r < -64'sd8388608) m_ovf = 1'b1;
            m_acc = wrap24(r);
        end
        m_first = last;
    endtask

    // Checks the result, optionally stalls with junk offered on the input, then completes the handshake.
    task automatic take_result(input int stall, input bit junk, input logic [23:0] w_sum,
                               input logic [5:0] w_exp, input bit w_ovf);
        logic [23:0] held;
        @(negedge i_clk);
        check("valid_high", o_valid, 1);
        check("ready_low", o_ready, 0);
        check("sum", o_sum, w_sum);
        check("exp", o_exp, w_exp);
        check("ovf", o_ovf, w_ovf);
        held = o_sum;
        for (int i = 0; i < stall; i++) begin
            if (junk) begin
                i_valid = 1'b1; i_pp = {$urandom, $urandom}; i_lane_en = 4'hF; i_last = 1'b1;
                i_exp = 6'($urandom);
            end
            @(negedge i_clk);
            check("stall_valid", o_valid, 1);
            check("stall_ready", o_ready, 0);
            check("stall_sum", o_sum, held);
            check("stall_exp", o_exp, w_exp);
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1 i_ready = 1'b0; i_valid = 1'b0; i_last = 1'b0;
        @(negedge i_clk);
        check("post_valid", o_valid, 0);
        check("post_ready", o_ready, 1);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        m_first = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [59:0] pp;
        int nb, st;
        i_rst = 1'b1; i_valid = 1'b0; i_pp = '0; i_lane_en = '0; i_exp = '0;
        i_last = 1'b0; i_ready = 1'b0; m_first = 1'b1; m_acc = 0; m_ovf = 1'b0; m_exp = '0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 1);
        check("rst_sum", o_sum, 0);
        check("rst_exp", o_exp, 0);
        check("rst_ovf", o_ovf, 0);

        pp = pack4(15'h3000, 15'h5000, 15'h0800, 15'h0000);
        beat(pp, 4'b1111, 6'd20, 1'b1);
        take_result(0, 1'b0, 24'h000800, 6'd20, 1'b0);

        beat(pp, 4'b0101, 6'd20, 1'b1);
        take_result(0, 1'b0, 24'h003800, 6'd20, 1'b0);

        pp = pack4(15'h3000, 15'h3000, 15'h3000, 15'h3000);
        beat(pp, 4'b1111, 6'd7, 1'b0);
        beat(pp, 4'b1111, 6'd9, 1'b0);
        beat(pp, 4'b1111, 6'd9, 1'b1);
        take_result(0, 1'b0, 24'h024000, 6'd7, 1'b0);

        pp = pack4(15'h0123, 15'h0456, 15'h0000, 15'h0000);
        beat(pp, 4'b0011, 6'd5, 1'b1);
        take_result(5, 1'b1, 24'h000579, 6'd5, 1'b0);

        pp = pack4(15'h3800, 15'h3800, 15'h3800, 15'h3800);
        for (int i = 0; i < 147; i++) beat(pp, 4'b1111, 6'd3, i == 146);
        take_result(0, 1'b0, 24'h80A000, 6'd3, 1'b1);

        pp = pack4(15'h0800, 15'h1111, 15'h2222, 15'h3333);
        beat(pp, 4'b1111, 6'd11, 1'b0);
        beat(pp, 4'b1111, 6'd11, 1'b0);
        do_reset();
        @(negedge i_clk);
        check("midrst_valid", o_valid, 0);
        check("midrst_ready", o_ready, 1);
        check("midrst_sum", o_sum, 0);
        check("midrst_ovf", o_ovf, 0);
        beat(pp, 4'b0001, 6'd12, 1'b1);
        take_result(0, 1'b0, 24'h000800, 6'd12, 1'b0);

        for (int g = 0; g < 25; g++) begin
            nb = $urandom_range(1, 6);
            st = $urandom_range(0, 3);
            i_exp = 6'($urandom);
            for (int b = 0; b < nb; b++)
                beat({$urandom, $urandom}, 4'($urandom), 6'($urandom), b == nb - 1);
            take_result(st, 1'($urandom), 24'(m_acc), m_exp, m_ovf);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/align_pp_accumulator.md
# align_pp_accumulator

Sequential consumer of aligned partial products in the MAC subsystem, directly downstream of the align stage. Each cycle it accepts up to `LANES` 15-bit two's-complement aligned partial products, all aligned to one group-wide max exponent. It reduces them with a lane adder and accumulates the result across a multi-beat group. On the beat marked last, it presents the signed sum together with the group exponent to the normalizer through a valid/ready handshake.

## Interface
- `LANES`, 4: aligned partial products accepted per beat
- `PP_W`, 15: aligned partial-product width (sign + 14-bit fixed point, G/R/S in low bits)
- `EXP_W`, 6: exponent width
- `ACC_W`, 24: accumulator width, signed; must be ≥ `PP_W + clog2(LANES)`
- `i_clk` in 1: clock; single clock domain
- `i_rst` in 1: reset; synchronous, active-high
- `i_valid` in 1: input beat valid
- `o_ready` out 1: block can accept a beat
- `i_pp` in `LANES*PP_W`: lane k at bits `[k*PP_W +: PP_W]`, two's complement
- `i_lane_en` in `LANES`: lane k contributes only when bit k = 1
- `i_exp` in `EXP_W`: group max_exp; sampled on first beat only
- `i_last` in 1: final beat of the group
- `o_valid` out 1: result valid
- `i_ready` in 1: downstream accepts the result
- `o_sum` out `ACC_W`: signed accumulated sum
- `o_exp` out `EXP_W`: group exponent
- `o_ovf` out 1: sticky signed-overflow flag for this group
- `number` out 51: constant cell-count estimate, equal to the sum of all instantiated primitive counts

## Operation
- A beat is accepted when `i_valid && o_ready`.
- Lane sum: each enabled lane is sign-extended from `PP_W` to `ACC_W` and the enabled lanes are added. Disabled lanes contribute 0.
- FSM states:
  - IDLE: `o_ready`=1, `o_valid`=0. On accept, `acc` ← lane sum, `exp` ← `i_exp`, `ovf` ← 0. If `i_last`, go to HOLD; otherwise go to ACC.
  - ACC: `o_ready`=1. On accept, `acc` ← `acc` + lane sum and `i_exp` is ignored. If `i_last`, go to HOLD.
  - HOLD: `o_valid`=1, `o_ready`=0. When `i_ready` is high, go to IDLE.
- Arithmetic is modulo 2^`ACC_W` (wraps). `ovf` is set when both operands of the accumulate add have the same sign and the result sign differs, and it stays set until the next group's first beat.
- A single-beat group (first beat also last) is legal.
- `o_sum`, `o_exp`, and `o_ovf` are registered, and they hold stable while `o_valid` is high and `i_ready` is low.
- While `o_ready`=0, `i_valid` is ignored and no input is consumed.
- Groups have no length limit; overflow is reported only through `o_ovf`.

## Timing
- Reset (`i_rst` high at a clock edge):
  - state → IDLE
  - `o_valid`=0, `o_ready`=1
  - `o_sum`=0, `o_exp`=0, `o_ovf`=0
  - Reset overrides any concurrent accept or handshake, and a partial group in progress is discarded.
- Latency: `o_valid` rises on the clock edge that accepts the last beat, so the result is visible the cycle after that beat.
- Throughput:
  - One beat per cycle within a group.
  - Each group costs one extra HOLD cycle minimum, during which `o_ready`=0.
  - A new group may start on the cycle after the HOLD→IDLE handshake.
- In HOLD with `i_ready` held low, the block stays in HOLD indefinitely with outputs frozen.
- `o_ready` is a function of state only; it has no combinational path from `i_valid` or `i_ready`.

## Structure
- Shared MAC package holds `PP_W`, `EXP_W`, and the FSM state encoding (IDLE=2'd0, ACC=2'd1, HOLD=2'd2).
- One sub-module, `pp_lane_adder`: a combinational sign-extend-and-sum tree built from `ADD` primitives, with a `number` output.
- The top contains the FSM, registers, accumulate `ADD#(ACC_W)`, and `MX` muxes. It sums every sub-block `number` into its own `number` output.

## Test plan
- Single-beat group: lanes 0x3000, 0x5000, 0x0800, 0x0000; `i_lane_en`=4'b1111; `i_exp`=20; `i_last`=1 → next cycle `o_valid`=1, `o_sum`=24'h000800, `o_exp`=20, `o_ovf`=0.
- Lane mask: same data with `i_lane_en`=4'b0101 → `o_sum`=24'h003800 (0x3000 + 0x0800).
- Three-beat group: every lane 0x3000 on each beat; `i_exp`=7 on the first beat, 9 on later beats → `o_sum`=24'h024000, `o_exp`=7.
- Backpressure: hold `i_ready`=0 for 5 cycles in HOLD while driving `i_valid`=1 → `o_sum` stable, `o_ready`=0, nothing consumed. After `i_ready`=1 for one cycle, the next cycle has `o_valid`=0 and `o_ready`=1.
- Overflow: 147 beats, every lane 0x3800 → `o_ovf`=1, `o_sum`=-8347648 (24'h80A000 wrapped).
- Reset mid-group: `i_rst` asserted after 2 accepted beats → next cycle `o_valid`=0, `o_ready`=1. A subsequent single-beat group of 0x0800 on lane 0 gives `o_sum`=24'h000800.
